// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parametrised UART receive frame controller.
// Oversampled start/data/parity/stop decode with 3-sample majority vote.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int LEN_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [LEN_WIDTH-1:0]      data_len,
  input  logic                      par_en,
  input  logic                      par_type,
  input  logic                      stop2,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      frm_err,
  output logic                      break_det,
  output logic                      busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [PRESCALE_WIDTH-1:0] P_MIN =
    PRESCALE_WIDTH'(4);
  localparam logic [LEN_WIDTH-1:0] L_MIN = LEN_WIDTH'(5);
  localparam logic [LEN_WIDTH-1:0] L_MAX =
    LEN_WIDTH'(DATA_WIDTH);

  logic [2:0]                state;
  logic [PRESCALE_WIDTH-1:0] ec;
  logic [PRESCALE_WIDTH-1:0] p_q;
  logic [PRESCALE_WIDTH-1:0] p_in;
  logic [PRESCALE_WIDTH-1:0] h;
  logic [LEN_WIDTH-1:0]      bc;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [LEN_WIDTH-1:0]      len_in;
  logic                      pen_q;
  logic                      pty_q;
  logic                      st2_q;
  logic                      s0;
  logic                      s1;
  logic                      vote_q;
  logic                      vote;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      pxor;
  logic                      allz;
  logic                      perr;
  logic                      ferr;
  logic                      sc;
  logic                      bit_end;
  logic                      last_stop;
  logic                      go;
  logic                      ferr_n;
  logic                      brk_n;

  assign p_in = (Prescale < P_MIN) ? P_MIN : Prescale;
  assign len_in =
    (data_len < L_MIN || data_len > L_MAX) ? L_MAX : data_len;
  assign h = p_q >> 1;
  assign bit_end = (ec == p_q - 1'b1);
  // with P=4 the third sample lands on the bit end itself
  assign vote = (ec == h + 1'b1)
    ? ((s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN))
    : vote_q;
  assign last_stop = !st2_q || sc;
  assign ferr_n = ferr | ~vote;
  assign brk_n = sc ? allz : (allz & ~vote);
  assign go = (state == IDLE && !RX_IN) ||
    (state == STOP && bit_end && last_stop && !RX_IN);
  assign busy = (state != IDLE);

  // frame configuration captured on every entry to START
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q   <= '0;
      len_q <= '0;
      pen_q <= 1'b0;
      pty_q <= 1'b0;
      st2_q <= 1'b0;
    end else if (go) begin
      p_q   <= p_in;
      len_q <= len_in;
      pen_q <= par_en;
      pty_q <= par_type;
      st2_q <= stop2;
    end
  end

  // edge counter: 0..P-1 per bit, parked at 0 when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ec <= '0;
    else if (state == IDLE || bit_end)
      ec <= '0;
    else
      ec <= ec + 1'b1;
  end

  // mid-bit samples and registered majority vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0     <= 1'b0;
      s1     <= 1'b0;
      vote_q <= 1'b0;
    end else begin
      if (ec == h - 1'b1) s0 <= RX_IN;
      if (ec == h) s1 <= RX_IN;
      if (ec == h + 1'b1) vote_q <= vote;
    end
  end

  // frame FSM, deserialiser, checks and frame-end pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bc         <= '0;
      shreg      <= '0;
      pxor       <= 1'b0;
      allz       <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      sc         <= 1'b0;
      rx_data    <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      break_det  <= 1'b0;
      if (go) begin
        state <= START;
        bc    <= '0;
        shreg <= '0;
        pxor  <= 1'b0;
        allz  <= 1'b1;
        perr  <= 1'b0;
        ferr  <= 1'b0;
        sc    <= 1'b0;
      end
      unique case (1'b1)
        (state == IDLE): ;
        (state == START):
          if (bit_end) state <= vote ? IDLE : DATA;
        (state == DATA):
          if (bit_end) begin
            shreg <= shreg | (DATA_WIDTH'(vote) << bc);
            pxor  <= pxor ^ vote;
            allz  <= allz & ~vote;
            bc    <= bc + 1'b1;
            if (bc == len_q - 1'b1)
              state <= pen_q ? PARITY : STOP;
          end
        (state == PARITY):
          if (bit_end) begin
            perr  <= vote ^ pxor ^ pty_q;
            allz  <= allz & ~vote;
            state <= STOP;
          end
        (state == STOP):
          if (bit_end) begin
            if (!last_stop) begin
              sc   <= 1'b1;
              ferr <= ferr_n;
              allz <= brk_n;
            end else begin
              if (!perr && !ferr_n) begin
                data_valid <= 1'b1;
                rx_data    <= shreg;
              end else begin
                par_err   <= perr;
                frm_err   <= ferr_n;
                break_det <= brk_n;
              end
              if (RX_IN) state <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and random line waveforms checked
// cycle by cycle against a bit-time reference model of the receiver.
module tb_uart_rx_frame_ctrl;

  localparam int DW = 8;
  localparam int N  = 20000;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic [3:0] data_len;
  logic       par_en;
  logic       par_type;
  logic       stop2;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       par_err;
  logic       frm_err;
  logic       break_det;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .data_len   (data_len),
    .par_en     (par_en),
    .par_type   (par_type),
    .stop2      (stop2),
    .rx_data    (rx_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .frm_err    (frm_err),
    .break_det  (break_det),
    .busy       (busy)
  );

  // per-cycle stimulus, observed and expected outputs
  // packed outputs: {busy, dv, pe, fe, bd, rx_data[7:0]}
  logic        ln  [N];
  logic [5:0]  cp  [N];
  logic [3:0]  cl  [N];
  logic        cpe [N];
  logic        cpt [N];
  logic        cs2 [N];
  logic [12:0] ob  [N];
  logic [12:0] ex  [N];
  logic        eb  [N];
  logic        edv [N];
  logic        epe [N];
  logic        efe [N];
  logic        ebd [N];
  logic [7:0]  erv [N];

  int         wr;
  int         npass;
  int         nchk;
  logic [5:0] k_p;
  logic [3:0] k_l;
  logic       k_pe;
  logic       k_pt;
  logic       k_s2;

  task automatic chk(input string tag, input int idx,
                     input logic [31:0] o, input logic [31:0] e);
    nchk++;
    assert (o === e) npass++;
    else $error("FAIL %s[%0d] observed=%h expected=%h",
                tag, idx, o, e);
  endtask

  function automatic int clp(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  function automatic int cll(input int l);
    return (l < 5 || l > DW) ? DW : l;
  endfunction

  task automatic push(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (wr < N) begin
        ln[wr]  = v;
        cp[wr]  = k_p;
        cl[wr]  = k_l;
        cpe[wr] = k_pe;
        cpt[wr] = k_pt;
        cs2[wr] = k_s2;
      end
      wr++;
    end
  endtask

  // transmit one frame; config is valid only on its first cycle
  // when scr is set, garbage otherwise
  task automatic send(input logic [7:0] d, input int p, input int l,
                      input logic pe, input logic pt, input logic s2,
                      input logic inv, input logic b1, input logic b2,
                      input logic scr);
    int   P;
    int   L;
    logic par;
    k_p  = 6'(p);
    k_l  = 4'(l);
    k_pe = pe;
    k_pt = pt;
    k_s2 = s2;
    P = clp(p);
    L = cll(l);
    push(1'b0, 1);
    if (scr) begin
      k_p  = 6'($urandom);
      k_l  = 4'($urandom);
      k_pe = 1'($urandom);
      k_pt = 1'($urandom);
      k_s2 = 1'($urandom);
    end
    push(1'b0, P - 1);
    par = pt;
    for (int i = 0; i < L; i++) begin
      push(d[i], P);
      par ^= d[i];
    end
    if (pe) push(par ^ inv, P);
    push(~b1, P);
    if (s2) push(~b2, P);
  endtask

  function automatic logic lv(input int i);
    return (i < wr) ? ln[i] : 1'b1;
  endfunction

  // majority of the three mid-bit samples of the bit whose
  // first counted cycle is a
  function automatic logic vt(input int a, input int h);
    logic x;
    logic y;
    logic z;
    x = lv(a + h - 1);
    y = lv(a + h);
    z = lv(a + h + 1);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // bit-time reference: frames located by start detection, bits
  // decoded at s + k*P, frame end at s + nbits*P - 1
  task automatic run_model();
    int t;
    int tl;
    int s;
    int P;
    int L;
    int h;
    int e;
    int n;
    logic pe;
    logic pt;
    logic s2;
    logic xr;
    logic az;
    logic pb;
    logic v1;
    logic v2;
    logic pr;
    logic fr;
    logic [7:0] dd;
    logic [7:0] cur;
    for (int i = 0; i < wr; i++) begin
      eb[i]  = 1'b0;
      edv[i] = 1'b0;
      epe[i] = 1'b0;
      efe[i] = 1'b0;
      ebd[i] = 1'b0;
      erv[i] = 8'h00;
    end
    t  = 0;
    tl = -1;
    while (t < wr) begin
      if (tl < 0) begin
        if (ln[t]) begin
          t++;
          continue;
        end
        tl = t;
      end
      s  = tl + 1;
      P  = clp(int'(cp[tl]));
      L  = cll(int'(cl[tl]));
      pe = cpe[tl];
      pt = cpt[tl];
      s2 = cs2[tl];
      h  = P / 2;
      if (vt(s, h)) begin
        for (int i = tl; i < tl + P && i < wr; i++) eb[i] = 1'b1;
        t  = tl + P;
        tl = -1;
      end else begin
        dd = 8'h00;
        xr = 1'b0;
        az = 1'b1;
        for (int k = 1; k <= L; k++) begin
          pb = vt(s + k * P, h);
          dd[k-1] = pb;
          xr ^= pb;
          az &= ~pb;
        end
        n  = L + 1;
        pr = 1'b0;
        if (pe) begin
          pb = vt(s + n * P, h);
          pr = pb ^ xr ^ pt;
          az &= ~pb;
          n++;
        end
        v1 = vt(s + n * P, h);
        n++;
        fr = ~v1;
        az &= ~v1;
        if (s2) begin
          v2 = vt(s + n * P, h);
          fr |= ~v2;
          n++;
        end
        e = s + n * P - 1;
        for (int i = tl; i < e && i < wr; i++) eb[i] = 1'b1;
        if (e < wr) begin
          if (!pr && !fr) begin
            edv[e] = 1'b1;
            erv[e] = dd;
          end else begin
            epe[e] = pr;
            efe[e] = fr;
            ebd[e] = az;
          end
        end
        if (e < wr && !ln[e]) begin
          tl = e;
          t  = e;
        end else begin
          tl = -1;
          t  = e + 1;
        end
      end
    end
    cur = 8'h00;
    for (int i = 0; i < wr; i++) begin
      if (edv[i]) cur = erv[i];
      ex[i] = {eb[i], edv[i], epe[i], efe[i], ebd[i], cur};
    end
  endtask

  function automatic int cnt(input int a, input int b, input int bp);
    int n;
    n = 0;
    for (int i = a; i < b; i++) if (ob[i][bp]) n++;
    return n;
  endfunction

  initial begin
    int w [7];
    int c;
    int p1;
    int p2;
    npass = 0;
    nchk  = 0;
    wr    = 0;
    k_p  = 6'd8;
    k_l  = 4'd8;
    k_pe = 1'b0;
    k_pt = 1'b0;
    k_s2 = 1'b0;

    push(1'b1, 20);
    w[0] = wr;
    send(8'hA5, 8, 8, 0, 0, 0, 0, 0, 0, 0);
    push(1'b1, 20);
    w[1] = wr;
    send(8'h55, 16, 7, 1, 0, 0, 0, 0, 0, 0);
    push(1'b1, 20);
    send(8'h55, 16, 7, 1, 0, 0, 1, 0, 0, 0);
    push(1'b1, 20);
    w[2] = wr;
    k_p = 6'd8;
    push(1'b0, 2);
    push(1'b1, 30);
    w[3] = wr;
    send(8'h5A, 8, 8, 0, 0, 1, 0, 0, 1, 0);
    push(1'b1, 20);
    w[4] = wr;
    k_p  = 6'd8;
    k_l  = 4'd8;
    k_pe = 1'b1;
    k_pt = 1'b0;
    k_s2 = 1'b0;
    push(1'b0, 96);
    push(1'b1, 200);
    w[5] = wr;
    c = wr;
    send(8'h3C, 4, 8, 0, 0, 0, 0, 0, 0, 0);
    for (int i = c + 8; i < c + 40; i++) cp[i] = 6'd8;
    send(8'hC3, 8, 8, 0, 0, 0, 0, 0, 0, 0);
    push(1'b1, 40);
    w[6] = wr;
    for (int f = 0; f < 40; f++) begin
      send(8'($urandom), $urandom_range(0, 20),
           $urandom_range(0, 15), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           1'b1);
      push(1'b1, $urandom_range(0, 3));
    end
    push(1'b1, 100);
    chk("fits", 0, 32'(wr <= N), 32'd1);
    if (wr > N) wr = N;

    rst      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = '0;
    data_len = '0;
    par_en   = 1'b0;
    par_type = 1'b0;
    stop2    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 0, 32'({busy, data_valid, par_err, frm_err,
                         break_det, rx_data}), 32'd0);
    rst = 1'b1;
    for (int t = 0; t < wr; t++) begin
      RX_IN    = ln[t];
      Prescale = cp[t];
      data_len = cl[t];
      par_en   = cpe[t];
      par_type = cpt[t];
      stop2    = cs2[t];
      @(posedge clk);
      #1;
      ob[t] = {busy, data_valid, par_err, frm_err, break_det, rx_data};
    end

    run_model();
    for (int t = 0; t < wr; t++) chk("cycle", t, 32'(ob[t]), 32'(ex[t]));

    chk("a5_dv", 1, cnt(w[0], w[1], 11), 1);
    chk("a5_err", 1, cnt(w[0], w[1], 10) + cnt(w[0], w[1], 9) +
        cnt(w[0], w[1], 8), 0);
    chk("a5_busy", 1, cnt(w[0], w[1], 12), 80);
    chk("a5_data", 1, 32'(ob[w[1]-1][7:0]), 32'hA5);
    chk("par_dv", 2, cnt(w[1], w[2], 11), 1);
    chk("par_pe", 2, cnt(w[1], w[2], 10), 1);
    chk("par_fe", 2, cnt(w[1], w[2], 9), 0);
    chk("par_data", 2, 32'(ob[w[2]-1][7:0]), 32'h55);
    chk("gl_busy", 3, cnt(w[2], w[3], 12), 8);
    chk("gl_pulse", 3, cnt(w[2], w[3], 11) + cnt(w[2], w[3], 10) +
        cnt(w[2], w[3], 9) + cnt(w[2], w[3], 8), 0);
    chk("st2_fe", 4, cnt(w[3], w[4], 9), 1);
    chk("st2_dv", 4, cnt(w[3], w[4], 11), 0);
    chk("st2_bd", 4, cnt(w[3], w[4], 8), 0);
    chk("brk_bd", 5, cnt(w[4], w[5], 8), 1);
    chk("brk_fe", 5, cnt(w[4], w[5], 9), 1);
    chk("brk_pe", 5, cnt(w[4], w[5], 10), 1);
    chk("brk_dv", 5, cnt(w[4], w[5], 11), 0);
    c = 0;
    for (int i = w[4]; i < w[5]; i++) if (ob[i][8] && ob[i][12]) c++;
    chk("brk_b2b", 5, c, 1);
    p1 = -1;
    p2 = -1;
    for (int i = w[5]; i < w[6]; i++) begin
      if (ob[i][11]) begin
        if (p1 < 0) p1 = i;
        else if (p2 < 0) p2 = i;
      end
    end
    chk("b2b_dv", 6, cnt(w[5], w[6], 11), 2);
    chk("b2b_gap", 6, 32'(p2 - p1), 32'd80);
    chk("b2b_v1", 6, (p1 >= 0) ? 32'(ob[p1][7:0]) : 32'hFFFF_FFFF,
        32'h3C);
    chk("b2b_v2", 6, 32'(ob[w[6]-1][7:0]), 32'hC3);

    RX_IN    = 1'b0;
    Prescale = 6'd8;
    data_len = 4'd8;
    par_en   = 1'b0;
    stop2    = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 0, 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst", 0, 32'({busy, data_valid, par_err, frm_err,
                           break_det, rx_data}), 32'd0);
    RX_IN = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    c = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (data_valid | par_err | frm_err | break_det | busy) c++;
    end
    chk("post_rst", 0, c, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
